sound_sequencer: RTL and testbench

//  Drives the oscillator's freq/state/playSound inputs and consumes its at_max pulses.

---
 rtl/sound_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_sound_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer: plays fixed multi-note sound effects (EAT, DIE) on game
// event strobes, drives the oscillator freq/playSound inputs and turns the
// oscillator's at_max pulses into a square-wave speaker output.
// Optional feature macro: SOUND_SEQ_GAP_EN inserts a silent GAP state of
// TICK_CYCLES cycles between consecutive notes of an effect.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no effect in progress; outputs quiet, waiting for a request
//  PLAY  | a note of the selected effect is sounding (or resting)
//  GAP   | silent pause between two notes (only with SOUND_SEQ_GAP_EN)

module sound_sequencer #(
   parameter int TICK_CYCLES = 1000,
   parameter int DUR_W       = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       state_i,
   input  logic       eat_req_i,
   input  logic       die_req_i,
   input  logic       at_max_i,
   output logic [7:0] freq_o,
   output logic       playSound_o,
   output logic       speaker_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int            TW        = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic          EFF_EAT   = 1'b0;
   localparam logic          EFF_DIE   = 1'b1;

`ifdef SOUND_SEQ_GAP_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} fsm_t;
`else
   typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} fsm_t;
`endif

   fsm_t             state_q, state_d;
   logic             effect_q, effect_d;
   logic [1:0]       idx_q, idx_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [7:0]       freq_q, freq_d;
   logic             play_q, play_d;
   logic             speaker_q, speaker_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             load_en;
   logic             load_eff;
   logic [1:0]       load_idx;
   logic [7:0]       ld_freq;
   logic [DUR_W-1:0] ld_dur;
   logic             tick_wrap;
   logic [1:0]       last_idx;

   // Note ROM: {freq, dur} per effect and note index
   function automatic logic [8+DUR_W-1:0] note_rom(input logic eff, input logic [1:0] idx);
      logic [7:0]       f;
      logic [DUR_W-1:0] d;
      f = 8'd0;
      d = '0;
      if (eff == EFF_EAT) begin
         case (idx)
            2'd0:    begin f = 8'd40;  d = DUR_W'(2); end
            default: begin f = 8'd30;  d = DUR_W'(2); end
         endcase
      end else begin
         case (idx)
            2'd0:    begin f = 8'd60;  d = DUR_W'(3); end
            2'd1:    begin f = 8'd80;  d = DUR_W'(3); end
            2'd2:    begin f = 8'd100; d = DUR_W'(3); end
            default: begin f = 8'd140; d = DUR_W'(6); end
         endcase
      end
      return {f, d};
   endfunction

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         effect_q  <= EFF_EAT;
         idx_q     <= 2'd0;
         tick_q    <= '0;
         dur_q     <= '0;
         freq_q    <= 8'd0;
         play_q    <= 1'b0;
         speaker_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         effect_q  <= effect_d;
         idx_q     <= idx_d;
         tick_q    <= tick_d;
         dur_q     <= dur_d;
         freq_q    <= freq_d;
         play_q    <= play_d;
         speaker_q <= speaker_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state, note sequencing and registered-output decisions
   always_comb begin
      state_d   = state_q;
      effect_d  = effect_q;
      idx_d     = idx_q;
      tick_d    = tick_q;
      dur_d     = dur_q;
      freq_d    = freq_q;
      play_d    = play_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load_en   = 1'b0;
      load_eff  = effect_q;
      load_idx  = 2'd0;
      ld_freq   = 8'd0;
      ld_dur    = '0;
      tick_wrap = (tick_q == TICK_LAST);
      last_idx  = (effect_q == EFF_DIE) ? 2'd3 : 2'd1;
      // speaker follows at_max only while a real note sounds; rests hold it
      speaker_d = (state_q == ST_PLAY && play_q && at_max_i) ? ~speaker_q : speaker_q;

      if (!state_i) begin
         // mode OFF: abort silently, whatever the FSM was doing
         state_d   = ST_IDLE;
         effect_d  = EFF_EAT;
         idx_d     = 2'd0;
         tick_d    = '0;
         dur_d     = '0;
         freq_d    = 8'd0;
         play_d    = 1'b0;
         speaker_d = 1'b0;
         busy_d    = 1'b0;
      end else if (die_req_i) begin
         // DIE wins over EAT and restarts any effect in progress
         load_en  = 1'b1;
         load_eff = EFF_DIE;
         load_idx = 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (eat_req_i) begin
                  load_en  = 1'b1;
                  load_eff = EFF_EAT;
                  load_idx = 2'd0;
               end
            end
            ST_PLAY: begin
               if (tick_wrap) begin
                  tick_d = '0;
                  if (dur_q == '0) begin
                     if (idx_q == last_idx) begin
                        state_d   = ST_IDLE;
                        effect_d  = EFF_EAT;
                        idx_d     = 2'd0;
                        dur_d     = '0;
                        freq_d    = 8'd0;
                        play_d    = 1'b0;
                        speaker_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                     end else begin
`ifdef SOUND_SEQ_GAP_EN
                        state_d   = ST_GAP;
                        idx_d     = idx_q + 2'd1;
                        freq_d    = 8'd0;
                        play_d    = 1'b0;
                        speaker_d = 1'b0;
`else
                        load_en   = 1'b1;
                        load_eff  = effect_q;
                        load_idx  = idx_q + 2'd1;
`endif
                     end
                  end else begin
                     dur_d = dur_q - DUR_W'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`ifdef SOUND_SEQ_GAP_EN
            ST_GAP: begin
               // idx_q already points at the note that follows the gap
               if (tick_wrap) begin
                  load_en  = 1'b1;
                  load_eff = effect_q;
                  load_idx = idx_q;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end

      if (load_en) begin
         {ld_freq, ld_dur} = note_rom(load_eff, load_idx);
         state_d  = ST_PLAY;
         effect_d = load_eff;
         idx_d    = load_idx;
         tick_d   = '0;
         // duration 0 plays as a single unit
         dur_d    = (ld_dur == '0) ? '0 : ld_dur - DUR_W'(1);
         freq_d   = ld_freq;
         play_d   = (ld_freq != 8'd0);
         busy_d   = 1'b1;
      end
   end

   assign freq_o      = freq_q;
   assign playSound_o = play_q;
   assign speaker_o   = speaker_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Testbench for sound_sequencer: an effect-timeline model (start cycle plus
// note table) predicts every output each cycle; directed scenarios add
// hand-computed literal checks. Honours SOUND_SEQ_GAP_EN when defined.
`timescale 1ns/1ps
module tb_sound_sequencer;

   localparam int TK = 4;
`ifdef SOUND_SEQ_GAP_EN
   localparam int GAPC = TK;
`else
   localparam int GAPC = 0;
`endif
   localparam int EAT_DONE = 17 + GAPC;        // eat_req at cycle 0
   localparam int DIE_DONE = 64 + 3 * GAPC;    // DIE starting at cycle 4

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st  = 1'b1;
   logic       eat = 1'b0;
   logic       die = 1'b0;
   logic       atm = 1'b0;
   logic [7:0] freq;
   logic       play, spk, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   int t       = 0;
   int cyc     = 0;

   bit m_active = 1'b0;
   bit m_eff    = 1'b0;
   bit m_spk    = 1'b0;
   int m_start  = 0;
   logic tog_now;

   sound_sequencer #(.TICK_CYCLES(TK), .DUR_W(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .state_i    (st),
      .eat_req_i  (eat),
      .die_req_i  (die),
      .at_max_i   (atm),
      .freq_o     (freq),
      .playSound_o(play),
      .speaker_o  (spk),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   function automatic int rom_f(bit eff, int i);
      if (!eff) return (i == 0) ? 40 : 30;
      case (i)
         0:       return 60;
         1:       return 80;
         2:       return 100;
         default: return 140;
      endcase
   endfunction

   function automatic int rom_d(bit eff, int i);
      int d;
      if (!eff) d = 2;
      else      d = (i == 3) ? 6 : 3;
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int n_notes(bit eff);
      return eff ? 4 : 2;
   endfunction

   function automatic int total(bit eff);
      int s;
      s = 0;
      for (int i = 0; i < n_notes(eff); i++) s += rom_d(eff, i) * TK;
      return s + (n_notes(eff) - 1) * GAPC;
   endfunction

   // frequency at offset into effect; -1 inside a gap, -2 outside the effect
   function automatic int freq_at(bit eff, int off);
      int pos;
      pos = 0;
      for (int i = 0; i < n_notes(eff); i++) begin
         if (off < pos + rom_d(eff, i) * TK) return rom_f(eff, i);
         pos += rom_d(eff, i) * TK;
         if (i < n_notes(eff) - 1) begin
            if (off < pos + GAPC) return -1;
            pos += GAPC;
         end
      end
      return -2;
   endfunction

   function automatic bit live_f(bit act, bit eff, int start, int k);
      return act && (k - start) >= 0 && (k - start) < total(eff);
   endfunction

   function automatic int fq_f(bit act, bit eff, int start, int k);
      return live_f(act, eff, start, k) ? freq_at(eff, k - start) : -2;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0d cyc=%0d: got %0d, expected %0d", name, t, cyc, act, exp);
      end
   endtask

   assign tog_now = (fq_f(m_active, m_eff, m_start, cyc) > 0) && atm;

   // Model update: effect start/abort and speaker expectation for next cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst || !st) begin
         m_active <= 1'b0;
         m_spk    <= 1'b0;
      end else if (die) begin
         m_active <= 1'b1;
         m_eff    <= 1'b1;
         m_start  <= cyc + 1;
         m_spk    <= m_spk ^ tog_now;
      end else if (eat && !live_f(m_active, m_eff, m_start, cyc)) begin
         m_active <= 1'b1;
         m_eff    <= 1'b0;
         m_start  <= cyc + 1;
         m_spk    <= 1'b0;
      end else begin
         m_spk <= (fq_f(m_active, m_eff, m_start, cyc + 1) >= 0) ? (m_spk ^ tog_now) : 1'b0;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("m_freq", int'(freq),
             (fq_f(m_active, m_eff, m_start, cyc) > 0) ? fq_f(m_active, m_eff, m_start, cyc) : 0);
         chk("m_play", int'(play), int'(fq_f(m_active, m_eff, m_start, cyc) > 0));
         chk("m_busy", int'(busy), int'(live_f(m_active, m_eff, m_start, cyc)));
         chk("m_done", int'(done), int'(m_active && (cyc - m_start) == total(m_eff)));
         chk("m_spk",  int'(spk),  int'(m_spk));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      t = t + 1;
   endtask

   task automatic run_to(input int k);
      while (t < k) tick();
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;

      // idle after reset
      t = 0;
      run_to(20);
      chk("idle_freq", int'(freq), 0);
      chk("idle_play", int'(play), 0);
      chk("idle_spk",  int'(spk),  0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);

      // EAT effect timing
      eat = 1'b1; t = 0; tick(); eat = 1'b0;
      chk("eat_t1_freq", int'(freq), 40);
      chk("eat_t1_busy", int'(busy), 1);
      run_to(8);  chk("eat_t8_freq", int'(freq), 40);
`ifdef SOUND_SEQ_GAP_EN
      run_to(9);  chk("eat_gap9_freq", int'(freq), 0);
      chk("eat_gap9_busy", int'(busy), 1);
      run_to(12); chk("eat_gap12_freq", int'(freq), 0);
      run_to(13); chk("eat_t13_freq", int'(freq), 30);
      run_to(20); chk("eat_t20_freq", int'(freq), 30);
`else
      run_to(9);  chk("eat_t9_freq", int'(freq), 30);
      run_to(16); chk("eat_t16_freq", int'(freq), 30);
      chk("eat_t16_done", int'(done), 0);
`endif
      run_to(EAT_DONE);
      chk("eat_done", int'(done), 1);
      chk("eat_done_busy", int'(busy), 0);
      run_to(EAT_DONE + 1);
      chk("eat_done_pulse", int'(done), 0);
      run_to(30);

      // speaker from at_max every 5th cycle
      eat = 1'b1; t = 0; tick(); eat = 1'b0;
      while (t < 26) begin
         atm = (t % 5 == 1);
         if (t == 2) chk("spk_t2", int'(spk), 1);
         if (t == 7) chk("spk_t7", int'(spk), 0);
`ifdef SOUND_SEQ_GAP_EN
         if (t == 12) chk("spk_t12_gap", int'(spk), 0);
         if (t == 17) chk("spk_t17", int'(spk), 1);
`else
         if (t == 12) chk("spk_t12", int'(spk), 1);
         if (t == 17) chk("spk_after_done", int'(spk), 0);
`endif
         tick();
      end
      atm = 1'b0;
      chk("spk_idle", int'(spk), 0);
      run_to(30);

      // EAT pre-empted by DIE
      eat = 1'b1; t = 0; tick(); eat = 1'b0;
      run_to(3); die = 1'b1; tick(); die = 1'b0;
      chk("die_t4_freq", int'(freq), 60);
      run_to(15); chk("die_t15_freq", int'(freq), 60);
      chk("die_no_eat_done", int'(done), 0);
      run_to(DIE_DONE - 1); chk("die_last_freq", int'(freq), 140);
      run_to(DIE_DONE);
      chk("die_done", int'(done), 1);
      chk("die_done_busy", int'(busy), 0);
      run_to(DIE_DONE + 10);

      // DIE restarted by another DIE
      die = 1'b1; t = 0; tick(); die = 1'b0;
      run_to(5); die = 1'b1; tick(); die = 1'b0;
      chk("restart_t6", int'(freq), 60);
      run_to(17); chk("restart_t17", int'(freq), 60);
      run_to(18); chk("restart_t18", int'(freq), (GAPC > 0) ? 0 : 80);
      run_to(100);

      // simultaneous requests pick DIE, then reset mid-effect
      eat = 1'b1; die = 1'b1; t = 0; tick(); eat = 1'b0; die = 1'b0;
      chk("both_freq", int'(freq), 60);
      run_to(5); rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_freq", int'(freq), 0);
      run_to(80);

      // eat_req while busy ignored
      eat = 1'b1; t = 0; tick(); eat = 1'b0;
      run_to(4); eat = 1'b1; tick(); eat = 1'b0;
      run_to(EAT_DONE - 1); chk("eat_busy_ign", int'(done), 0);
      run_to(EAT_DONE);     chk("eat_busy_done", int'(done), 1);
      run_to(30);

      // mode OFF mid note 2 aborts; requests ignored while OFF
      die = 1'b1; t = 0; tick(); die = 1'b0;
      run_to(18);
      chk("off_pre_freq", int'(freq), 80);
      st = 1'b0; tick();
      chk("off_freq", int'(freq), 0);
      chk("off_play", int'(play), 0);
      chk("off_busy", int'(busy), 0);
      chk("off_done", int'(done), 0);
      eat = 1'b1; tick(); eat = 1'b0;
      chk("off_eat_ign", int'(busy), 0);
      run_to(25); st = 1'b1;
      run_to(40);
      chk("off_after_busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
